// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared FFT controller types and constants
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    localparam int TWF_ADDR_W = 9;
    localparam int FFT_LANES  = 8;
    localparam int FFT_N      = 512;

endpackage

// File: rtl/twf_mul_seq_ctrl.sv
// rtl/twf_mul_seq_ctrl.sv - twiddle-multiply stage sequencer (enable, ROM address, frame markers)
module twf_mul_seq_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int                 ADDR_W    = TWF_ADDR_W,
    parameter int                 LANES     = FFT_LANES,
    parameter int                 BEATS     = FFT_N / FFT_LANES,
    parameter logic [ADDR_W-1:0]  ADDR_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              valid_in,
    output logic              ready_in,
    output logic              mul_en,
    output logic [ADDR_W-1:0] mul_addr,
    output logic              valid_out,
    output logic              sof_out,
    output logic              eof_out,
    output logic              busy,
    output logic              frame_done,
    output logic              err_start,
    input  logic              clr_err
);

    localparam int                CNT_W     = $clog2(BEATS);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(LANES);

    seq_state_t        state_q;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic [CNT_W-1:0]  beat_cnt_d;
    logic [ADDR_W-1:0] mul_addr_q;
    logic [ADDR_W-1:0] mul_addr_d;
    logic              valid_out_q;
    logic              sof_q;
    logic              eof_q;
    logic              frame_done_q;
    logic              err_start_q;
    logic              first_beat;
    logic              last_beat;

    assign ready_in   = (state_q == RUN);
    assign mul_en     = valid_in & ready_in;
    assign first_beat = (beat_cnt_q == '0);
    assign last_beat  = (beat_cnt_q == LAST_BEAT);

    assign mul_addr   = mul_addr_q;
    assign valid_out  = valid_out_q;
    assign sof_out    = sof_q;
    assign eof_out    = eof_q;
    assign frame_done = frame_done_q;
    assign err_start  = err_start_q;
    assign busy       = (state_q != IDLE);

    // Next beat position after an accepted beat; address wraps naturally at the ROM depth.
    always_comb begin
        mul_addr_d = mul_addr_q + ADDR_STEP;
        beat_cnt_d = beat_cnt_q + 1'b1;
    end

    // Sequencer FSM with address/beat tracking and product-aligned output flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            mul_addr_q   <= ADDR_INIT;
            valid_out_q  <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            frame_done_q <= 1'b0;
            err_start_q  <= 1'b0;
        end else begin
            // Products appear one cycle after the enable, so flags trail mul_en by one cycle.
            valid_out_q  <= mul_en;
            sof_q        <= mul_en & first_beat;
            eof_q        <= mul_en & last_beat;
            frame_done_q <= mul_en & last_beat;

            if (clr_err) begin
                err_start_q <= 1'b0;
            end else if (start && (state_q != IDLE)) begin
                err_start_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (mul_en) begin
                        mul_addr_q <= mul_addr_d;
                        beat_cnt_q <= beat_cnt_d;
                        if (last_beat) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state_q    <= IDLE;
                    mul_addr_q <= ADDR_INIT;
                    beat_cnt_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_twf_mul_seq_ctrl.sv
// tb/tb_twf_mul_seq_ctrl.sv - self-checking bench for twf_mul_seq_ctrl
module tb_twf_mul_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       valid_in;
    logic       ready_in;
    logic       mul_en;
    logic [8:0] mul_addr;
    logic       valid_out;
    logic       sof_out;
    logic       eof_out;
    logic       busy;
    logic       frame_done;
    logic       err_start;
    logic       clr_err;

    int total;
    int bad;

    twf_mul_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .mul_en     (mul_en),
        .mul_addr   (mul_addr),
        .valid_out  (valid_out),
        .sof_out    (sof_out),
        .eof_out    (eof_out),
        .busy       (busy),
        .frame_done (frame_done),
        .err_start  (err_start),
        .clr_err    (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic       vin;
        logic       clr;
        logic       ready;
        logic       en;
        logic [8:0] addr;
        logic       vout;
        logic       sof;
        logic       eof;
        logic       done;
        logic       busy;
        logic       err;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic v, input logic c);
        rst      = r;
        start    = s;
        valid_in = v;
        clr_err  = c;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame: start cycle, beats with optional bubble / stray start / mid-frame reset, drain.
    task automatic run_frame(input int bub_at, input int nbub, input int err_at, input int rst_at);
        int   k;
        int   bl;
        int   vcnt;
        int   cyc;
        int   pk;
        logic pen;
        logic vin;
        logic st;
        logic r;
        drive(0, 1, 0, 0);
        chk("start_idle_busy", busy, 0);
        chk("start_idle_vout", valid_out, 0);
        chk("start_idle_eof", eof_out, 0);
        chk("start_idle_addr", mul_addr, 0);
        step();
        k = 0; bl = nbub; vcnt = 0; cyc = 0; pk = 0; pen = 0;
        while (k < 64) begin
            if (cyc > 400) begin
                chk("frame_timeout", cyc, 0);
                return;
            end
            vin = 1'b1;
            if (k == bub_at && bl > 0) begin
                vin = 1'b0;
                bl--;
            end
            st = (k == err_at);
            r  = (k == rst_at);
            drive(r, st, vin, 0);
            chk("run_ready", ready_in, 1);
            chk("run_en", mul_en, vin);
            chk("run_addr", mul_addr, (k * 8) % 512);
            chk("run_vout", valid_out, pen);
            chk("run_sof", sof_out, pen && pk == 0);
            chk("run_eof", eof_out, pen && pk == 63);
            chk("run_done", frame_done, pen && pk == 63);
            chk("run_busy", busy, 1);
            if (valid_out) vcnt++;
            step();
            cyc++;
            if (r) begin
                drive(0, 0, 0, 0);
                chk("rst_mid_busy", busy, 0);
                chk("rst_mid_addr", mul_addr, 0);
                chk("rst_mid_vout", valid_out, 0);
                chk("rst_mid_eof", eof_out, 0);
                chk("rst_mid_ready", ready_in, 0);
                step();
                return;
            end
            pen = vin;
            pk  = k;
            if (vin) k++;
        end
        // DRAIN: last product emitted, new beats refused
        drive(0, 0, 1, 0);
        chk("drain_ready", ready_in, 0);
        chk("drain_en", mul_en, 0);
        chk("drain_busy", busy, 1);
        chk("drain_vout", valid_out, 1);
        chk("drain_sof", sof_out, 0);
        chk("drain_eof", eof_out, 1);
        chk("drain_done", frame_done, 1);
        chk("drain_addr_wrap", mul_addr, 0);
        if (valid_out) vcnt++;
        chk("frame_vout_count", vcnt, 64);
        if (err_at >= 0) chk("err_sticky", err_start, 1);
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive(1, 0, 0, 0);
        repeat (3) step();

        //            rst st vin clr  rdy en addr vo sof eof dn bsy err
        vecs[0]  = '{0, 0, 1, 0,   0, 0, 9'd0,  0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 1, 0,   0, 0, 9'd0,  0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 1, 0,   0, 0, 9'd0,  0, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 1, 0,   1, 1, 9'd0,  0, 0, 0, 0, 1, 0};
        vecs[4]  = '{0, 0, 1, 0,   1, 1, 9'd8,  1, 1, 0, 0, 1, 0};
        vecs[5]  = '{0, 0, 0, 0,   1, 0, 9'd16, 1, 0, 0, 0, 1, 0};
        vecs[6]  = '{0, 0, 1, 0,   1, 1, 9'd16, 0, 0, 0, 0, 1, 0};
        vecs[7]  = '{0, 1, 1, 0,   1, 1, 9'd24, 1, 0, 0, 0, 1, 0};
        vecs[8]  = '{0, 0, 1, 1,   1, 1, 9'd32, 1, 0, 0, 0, 1, 1};
        vecs[9]  = '{0, 1, 1, 1,   1, 1, 9'd40, 1, 0, 0, 0, 1, 0};
        vecs[10] = '{0, 0, 0, 0,   1, 0, 9'd48, 1, 0, 0, 0, 1, 0};
        vecs[11] = '{1, 0, 1, 0,   1, 1, 9'd48, 0, 0, 0, 0, 1, 0};
        vecs[12] = '{0, 0, 1, 0,   0, 0, 9'd0,  0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].vin, vecs[i].clr);
            chk($sformatf("v%0d_ready", i), ready_in, vecs[i].ready);
            chk($sformatf("v%0d_en", i), mul_en, vecs[i].en);
            chk($sformatf("v%0d_addr", i), mul_addr, vecs[i].addr);
            chk($sformatf("v%0d_vout", i), valid_out, vecs[i].vout);
            chk($sformatf("v%0d_sof", i), sof_out, vecs[i].sof);
            chk($sformatf("v%0d_eof", i), eof_out, vecs[i].eof);
            chk($sformatf("v%0d_done", i), frame_done, vecs[i].done);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("v%0d_err", i), err_start, vecs[i].err);
            step();
        end

        // plain frame
        run_frame(-1, 0, -1, -1);
        // bubbles on beat 10 (address 80 held three cycles)
        run_frame(10, 3, -1, -1);
        // stray start at beat 20, frame still completes; then clear
        run_frame(-1, 0, 20, -1);
        drive(0, 0, 0, 1);
        chk("err_before_clr", err_start, 1);
        step();
        drive(0, 0, 0, 0);
        chk("err_after_clr", err_start, 0);
        step();
        // reset at beat 30, then full frames back to back
        run_frame(-1, 0, -1, 30);
        run_frame(-1, 0, -1, -1);
        run_frame(-1, 0, -1, -1);
        drive(0, 0, 0, 0);
        chk("final_busy", busy, 0);
        chk("final_vout", valid_out, 0);
        chk("final_err", err_start, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
